// File: rtl/alu_seq.sv
// alu_seq -- handshaked, multi-cycle successor to the combinational ALU.
//
// Operands and a 4-bit opcode arrive over a valid/ready input channel; the
// registered result and flags leave over a valid/ready output channel.
// Logic/arith ops finish in one cycle, shifts iterate one bit per cycle, and
// the optional multiplier iterates shift-add for WIDTH cycles.
//
// Optional feature macro: ALU_MUL_EN (adds op 11 = unsigned multiply).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand/op presented          in_ready  accepting (IDLE only)
//   in0, in1   operands (shifts use in1[SHW-1:0] as amount)
//   op         0 AND 1 OR 2 ADD 3 SUB 4 SLT 5 NOR 6 SRL 7 SLL 8 SRA 9 SLTU
//              10 XOR 11 MUL (macro) 12-15 illegal
//   out_valid  result held until taken      out_ready consumer takes result
//   out        result
//   of_detect  signed overflow (ADD/SUB)
//   carry      ADD carry-out; SUB no-borrow; MUL high product nonzero
//   zero       out == 0
//   err        illegal opcode
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             of_detect,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // counter must reach WIDTH for MUL
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2,  OP_SUB  = 4'd3,
    OP_SLT = 4'd4, OP_NOR = 4'd5, OP_SRL = 4'd6,  OP_SLL  = 4'd7,
    OP_SRA = 4'd8, OP_SLTU = 4'd9, OP_XOR = 4'd10, OP_MUL = 4'd11
  } op_e;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_e;
`endif

  state_e           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;       // shift operand, or multiplier / product low half
  logic [CW-1:0]    cnt;       // remaining iterations
  logic [WIDTH-1:0] res;
  logic             of_q, carry_q, zero_q, err_q;

  logic             accept, is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res, shift_nxt;
  logic             sc_of, sc_carry, sc_err;

  assign accept   = in_valid && in_ready;
  assign shamt    = in1[SHW-1:0];
  assign is_shift = (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  assign sum      = {1'b0, in0} + {1'b0, in1};
  assign diff     = {1'b0, in0} - {1'b0, in1};

  // Single-cycle result, computed straight from the inputs at accept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    sc_res   = '0;
    sc_of    = 1'b0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    case (op)
      OP_AND:  sc_res = in0 & in1;
      OP_OR:   sc_res = in0 | in1;
      OP_NOR:  sc_res = ~(in0 | in1);
      OP_XOR:  sc_res = in0 ^ in1;
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_of    = (in0[MSB] == in1[MSB]) && (sum[MSB] != in0[MSB]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = ~diff[WIDTH];  // 1 = no borrow
        sc_of    = (in0[MSB] != in1[MSB]) && (diff[MSB] != in0[MSB]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(in0) < $signed(in1)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, in0 < in1};
      // Only registered as the result when the shift amount is zero.
      OP_SRL, OP_SLL, OP_SRA: sc_res = in0;
      default: sc_err = 1'b1;
    endcase
  end

  // One shift step; SRA re-inserts the MSB, which stays the original sign.
  always_comb begin
    shift_nxt = acc;
    case (op_q)
      OP_SRL:  shift_nxt = acc >> 1;
      OP_SLL:  shift_nxt = acc << 1;
      OP_SRA:  shift_nxt = {acc[MSB], acc[MSB:1]};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add: {hi, acc} shifts right each step, adding the multiplicand
  // into hi whenever the current multiplier bit (acc[0]) is set.
  logic [WIDTH-1:0] mcand, hi;
  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] mul_lo;
  assign madd   = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_lo = {madd[0], acc[MSB:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (accept) begin
          if (is_shift && shamt != '0) state_nxt = S_SHIFT;
`ifdef ALU_MUL_EN
          else if (op == OP_MUL)       state_nxt = S_MUL;
`endif
          else                         state_nxt = S_DONE;
        end
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:   if (cnt == CW'(1)) state_nxt = S_DONE;
`endif
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so outputs read 0 during and right after reset.
      op_q    <= '0;
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      of_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      hi      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (accept) begin
            op_q    <= op;
            acc     <= in0;
            cnt     <= {1'b0, shamt};
            // Iterative ops overwrite these when they finish.
            res     <= sc_res;
            of_q    <= sc_of;
            carry_q <= sc_carry;
            err_q   <= sc_err;
            zero_q  <= (sc_res == '0) && !sc_err;
`ifdef ALU_MUL_EN
            mcand   <= in1;
            hi      <= '0;
            if (op == OP_MUL) cnt <= CW'(WIDTH);
`endif
          end
        S_SHIFT: begin
          acc <= shift_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res     <= shift_nxt;
            zero_q  <= (shift_nxt == '0);
            of_q    <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc <= mul_lo;
          hi  <= madd[WIDTH:1];
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res     <= mul_lo;
            zero_q  <= (mul_lo == '0);
            carry_q <= |madd[WIDTH:1];
            of_q    <= 1'b0;
            err_q   <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign out       = out_valid ? res : '0;
  assign of_detect = out_valid && of_q;
  assign carry     = out_valid && carry_q;
  assign zero      = out_valid && zero_q;
  assign err       = out_valid && err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. The block takes WIDTH-bit operands and a 4-bit opcode over a valid/ready input channel. It returns a full WIDTH-bit registered result plus flags over a valid/ready output channel. Logic ops complete in one cycle; shifts iterate one bit per cycle; the optional multiplier iterates shift-add. It sits between the decode/operand-fetch stage and writeback of the RISC-V core.

## Interface
- WIDTH, 32, operand/result width; power of two, >= 8. Derived localparam SHW = $clog2(WIDTH).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts; high only in IDLE and rst low
- in0  in  WIDTH  operand A
- in1  in  WIDTH  operand B; shifts use in1[SHW-1:0] only as shift amount
- op  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 NOR, 6 SRL, 7 SLL, 8 SRA, 9 SLTU, 10 XOR, 11 MUL (macro), 12-15 illegal
- out_valid  out  1  result held until taken
- out_ready  in  1  consumer takes result
- out  out  WIDTH  result
- of_detect  out  1  signed overflow (ADD/SUB only, else 0)
- carry  out  1  ADD: carry-out bit WIDTH; SUB: 1 = no borrow (in0 >= in1 unsigned); else 0
- zero  out  1  out == 0
- err  out  1  illegal op (or 11 without macro)

## Operation
- States: IDLE, SHIFT, MUL, DONE. Reset -> IDLE.
- IDLE: accept on in_valid && in_ready; latch op/operands.
- Single-cycle ops (0-5, 9, 10, illegal): compute, register result and flags -> DONE.
- Shifts: latch in0 and shamt. If shamt == 0 -> DONE with out = in0. Otherwise go to SHIFT.
  - SHIFT: shift one bit per cycle, decrement counter, -> DONE when it reaches 0.
  - SRA fills with the original sign bit.
- Overflow rules:
  - ADD: of = in0[MSB]==in1[MSB] && out[MSB]!=in0[MSB].
  - SUB: of = in0[MSB]!=in1[MSB] && out[MSB]!=in0[MSB].
- SLT/SLTU: out = {WIDTH-1 zeros, less}.
- Illegal op: out = 0, err = 1, other flags 0.
- DONE: out_valid = 1; out and flags stable. On out_ready -> IDLE. The transfer cycle does not also accept a new op.
- Flags are registered with out and valid only while out_valid = 1.
- rst at any time: immediate return to IDLE, in-flight op discarded.

## Timing
- Accept at edge t:
  - single-cycle op: out_valid from t+1.
  - shift: out_valid from t+1+shamt (max t+WIDTH).
  - MUL: out_valid from t+1+WIDTH.
- in_ready is combinational from state; low from accept until the edge after out_valid && out_ready.
- Peak throughput: one op per 2 cycles.
- While rst is high, all outputs are 0 except in_ready, which is also 0. Datapath registers reset to 0.
- First accept is possible on the first edge after rst falls.
- in0/in1/op may change after accept; the result is unaffected.

## Configuration
- ALU_MUL_EN defined:
  - op 11 = unsigned shift-add multiply, out = low WIDTH bits of in0*in1.
  - WIDTH iterations in state MUL; carry = 1 if any high product bit is nonzero; of_detect = 0.
- ALU_MUL_EN undefined:
  - no MUL state or multiplier logic.
  - op 11 treated as illegal: one-cycle, out = 0, err = 1.

## Test plan (WIDTH=32)
- ADD 0x7FFFFFFF + 0x00000001 -> out 0x80000000, of_detect 1, carry 0, zero 0, out_valid one cycle after accept.
- SUB 0x7FFFFFFF - 0x80000000 -> 0xFFFFFFFF, of_detect 1, carry 0; SLT same operands -> 0; SLTU -> 1.
- SRA 0x80000000 by in1=0x21 (shamt 1) -> 0xC0000000 at t+2; SLL 0x1 by 31 -> 0x80000000 at t+32; shamt 0 -> in0 at t+1.
- Backpressure: hold out_ready low 5 cycles after out_valid -> out/flags stable, in_ready 0, concurrent in_valid ignored; release -> one transfer, in_ready 1 next cycle.
- Assert rst mid-SRL by 20 at cycle 10 -> out_valid/out/flags 0 immediately; after release, in_ready 1 and a fresh AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
- ALU_MUL_EN: 0x0000FFFF * 0x00010001 -> 0xFFFFFFFF, carry 0, out_valid at t+33. Without macro: op 11 -> out 0, err 1 at t+1. Op 15 -> err 1 in both builds.
